// File: rtl/fetch_prefetch_queue.sv
// rtl/fetch_prefetch_queue.sv - instruction fetch PC plus in-order prefetch FIFO feeding the IF/ID stage
module fetch_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic                       clock,
    input  logic                       reset,
    output logic                       imem_req,
    output logic [15:0]                imem_addr,
    input  logic                       imem_ready,
    input  logic [15:0]                imem_rdata,
    input  logic                       redirect,
    input  logic [15:0]                redirect_target,
    output logic                       ifid_valid,
    input  logic                       ifid_ready,
    output logic [15:0]                ifid_ir,
    output logic [15:0]                ifid_pcplus,
    output logic [$clog2(DEPTH):0]     queue_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [15:0]   ir_mem  [DEPTH];
    logic [15:0]   pcp_mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [15:0]   fetch_pc;
    logic          push;
    logic          pop;

    // A pop while full only frees space for the next cycle, since imem_req
    // looks at the registered count.
    assign imem_req    = !reset && !redirect && (count < FULL);
    assign imem_addr   = fetch_pc;
    assign push        = imem_req && imem_ready;
    assign ifid_valid  = (count != '0);
    assign pop         = ifid_valid && ifid_ready && !redirect && !reset;
    assign ifid_ir     = ifid_valid ? ir_mem[rd_ptr]  : 16'h0000;
    assign ifid_pcplus = ifid_valid ? pcp_mem[rd_ptr] : 16'h0000;
    assign queue_count = count;

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else if (redirect) begin
            fetch_pc <= {redirect_target[15:1], 1'b0};
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + 1'b1;
                fetch_pc <= fetch_pc + 16'd2;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            ir_mem[wr_ptr]  <= imem_rdata;
            pcp_mem[wr_ptr] <= fetch_pc + 16'd2;
        end
    end
endmodule
